// File: rtl/display_timing_pkg.sv
// Shared 480p timing constants, FSM state encoding and a window-compare helper
// for the display timing generator.
package display_timing_pkg;

  localparam int H_RES_480  = 640;
  localparam int H_FP_480   = 16;
  localparam int H_SYNC_480 = 96;
  localparam int H_BP_480   = 48;
  localparam int H_TOT_480  = H_RES_480 + H_FP_480 + H_SYNC_480 + H_BP_480;

  localparam int V_RES_480  = 480;
  localparam int V_FP_480   = 10;
  localparam int V_SYNC_480 = 2;
  localparam int V_BP_480   = 33;
  localparam int V_TOT_480  = V_RES_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // True when lo <= pos < hi.
  function automatic logic in_window(input logic [9:0] pos,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/display_timing_480p_pix_ce.sv
// Pixel clock-enable generator: free-running divide-by-CE_DIV counter whose
// registered pix_stb marks the last system-clock cycle of each pixel period.
module pix_ce_gen
  import display_timing_pkg::*;
#(
  parameter int CE_DIV = 4
) (
  input  logic clk_100m,
  input  logic rst,
  output logic pix_stb
);

  localparam int DW = $clog2(CE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CE_DIV - 2);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0] div_r;

  // Divider and strobe; pix_stb is raised one cycle early so it lines up with div_r == CE_DIV-1.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      div_r   <= '0;
      pix_stb <= 1'b0;
    end else begin
      if (div_r == DIV_LAST) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + DIV_ONE;
      end
      pix_stb <= (div_r == DIV_PRE);
    end
  end

endmodule

// File: rtl/display_timing_480p.sv
// Display timing generator with run/idle control that starts and stops video
// only on frame boundaries; all pixel-rate outputs update after pix_stb.
module display_timing_480p
  import display_timing_pkg::*;
#(
  parameter int   H_RES  = H_RES_480,
  parameter int   H_FP   = H_FP_480,
  parameter int   H_SYNC = H_SYNC_480,
  parameter int   H_BP   = H_BP_480,
  parameter int   V_RES  = V_RES_480,
  parameter int   V_FP   = V_FP_480,
  parameter int   V_SYNC = V_SYNC_480,
  parameter int   V_BP   = V_BP_480,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0,
  parameter int   CE_DIV = 4,
  parameter int   FC_W   = 16
) (
  input  logic            clk_100m,
  input  logic            rst,
  input  logic            en,
  output logic            pix_stb,
  output logic [9:0]      sx,
  output logic [9:0]      sy,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic            line_start,
  output logic            frame_start,
  output logic            vblank_start,
  output logic            running,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT     = 10'(H_RES);
  localparam logic [9:0] V_ACT     = 10'(V_RES);
  localparam logic [9:0] H_SYNC_LO = 10'(H_RES + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_RES + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_RES + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_RES + V_FP + V_SYNC);
  localparam logic [FC_W-1:0] FC_ONE = FC_W'(1'b1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [9:0] sx_nxt_s;
  logic [9:0] sy_nxt_s;
  logic       last_px_s;
  logic       frame_done_s;
  logic       active_nxt_s;

  pix_ce_gen #(.CE_DIV(CE_DIV)) u_pix_ce (
    .clk_100m (clk_100m),
    .rst      (rst),
    .pix_stb  (pix_stb)
  );

  // Next state and next raster position; counters hold while idle.
  always_comb begin
    state_nxt_s  = state_r;
    sx_nxt_s     = sx;
    sy_nxt_s     = sy;
    last_px_s    = (sx == H_LAST) && (sy == V_LAST);
    frame_done_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (pix_stb && en) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // A re-request wins over the end-of-frame stop.
        if (en) begin
          state_nxt_s = ST_RUN;
        end else if (pix_stb && last_px_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (pix_stb && (state_r != ST_IDLE)) begin
      frame_done_s = last_px_s;
      if (sx == H_LAST) begin
        sx_nxt_s = 10'd0;
        if (sy == V_LAST) begin
          sy_nxt_s = 10'd0;
        end else begin
          sy_nxt_s = sy + 10'd1;
        end
      end else begin
        sx_nxt_s = sx + 10'd1;
      end
    end else begin
      frame_done_s = 1'b0;
    end

    active_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // Registered raster state and video outputs, all derived from the next position.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sx          <= 10'd0;
      sy          <= 10'd0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      running     <= 1'b0;
      frame_count <= '0;
    end else begin
      state_r <= state_nxt_s;
      sx      <= sx_nxt_s;
      sy      <= sy_nxt_s;
      hsync   <= (active_nxt_s && in_window(sx_nxt_s, H_SYNC_LO, H_SYNC_HI)) ? H_POL : ~H_POL;
      vsync   <= (active_nxt_s && in_window(sy_nxt_s, V_SYNC_LO, V_SYNC_HI)) ? V_POL : ~V_POL;
      de      <= active_nxt_s && (sx_nxt_s < H_ACT) && (sy_nxt_s < V_ACT);
      running <= active_nxt_s;
      if (frame_done_s) begin
        frame_count <= frame_count + FC_ONE;
      end else begin
        frame_count <= frame_count;
      end
    end
  end

  assign line_start   = pix_stb & running & (sx == 10'd0);
  assign frame_start  = line_start & (sy == 10'd0);
  assign vblank_start = line_start & (sy == V_ACT);

endmodule

// File: tb/tb_display_timing_480p.sv
// Scoreboard bench for display_timing_480p using a shrunken raster so several
// frames fit in a short run; a position/arithmetic model predicts every cycle.
module tb_display_timing_480p;

  localparam int   H_RES = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int   V_RES = 6, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam logic H_POL = 1'b0, V_POL = 1'b0;
  localparam int   CE_DIV = 4, FC_W = 2;
  localparam int   H_TOT = H_RES + H_FP + H_SYNC + H_BP;
  localparam int   V_TOT = V_RES + V_FP + V_SYNC + V_BP;
  localparam int   FR = H_TOT * V_TOT * CE_DIV;

  logic            clk_100m = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            pix_stb, hsync, vsync, de;
  logic            line_start, frame_start, vblank_start, running;
  logic [9:0]      sx, sy;
  logic [FC_W-1:0] frame_count;

  display_timing_480p #(
    .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL), .CE_DIV(CE_DIV), .FC_W(FC_W)
  ) dut (
    .clk_100m(clk_100m), .rst(rst), .en(en), .pix_stb(pix_stb),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
    .line_start(line_start), .frame_start(frame_start),
    .vblank_start(vblank_start), .running(running), .frame_count(frame_count)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct packed {
    logic            stb;
    logic [9:0]      sx;
    logic [9:0]      sy;
    logic            hs;
    logic            vs;
    logic            de;
    logic            ls;
    logic            fs;
    logic            vb;
    logic            run;
    logic [FC_W-1:0] fc;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference model: clock phase within the pixel, raster position, video on/off,
  // en level at the previous edge (low means a stop is pending), frames completed.
  int mdiv, mx, my, mfc;
  bit mrun, mprev;

  function automatic rec_t sample();
    rec_t r;
    r.stb = pix_stb; r.sx = sx; r.sy = sy; r.hs = hsync; r.vs = vsync; r.de = de;
    r.ls = line_start; r.fs = frame_start; r.vb = vblank_start; r.run = running;
    r.fc = frame_count;
    return r;
  endfunction

  function automatic rec_t reset_rec();
    rec_t r;
    r = '0;
    r.hs = ~H_POL;
    r.vs = ~V_POL;
    return r;
  endfunction

  task automatic compare(input string name, input rec_t got, input rec_t exp);
    checks++;
    if (got == exp) begin
      passes++;
    end else begin
      $display("FAIL %s cyc=%0d: got stb=%0d sx=%0d sy=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d vb=%0d run=%0d fc=%0d, need stb=%0d sx=%0d sy=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d vb=%0d run=%0d fc=%0d",
               name, cyc, got.stb, got.sx, got.sy, got.hs, got.vs, got.de, got.ls, got.fs, got.vb, got.run, got.fc,
               exp.stb, exp.sx, exp.sy, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.vb, exp.run, exp.fc);
    end
  endtask

  // Expected outputs for the cycle currently presented.
  function automatic void present();
    rec_t r;
    bit   stb;
    stb   = (mdiv == CE_DIV - 1);
    r.stb = stb;
    r.sx  = 10'(mx);
    r.sy  = 10'(my);
    r.hs  = (mrun && mx >= H_RES + H_FP && mx < H_RES + H_FP + H_SYNC) ? H_POL : ~H_POL;
    r.vs  = (mrun && my >= V_RES + V_FP && my < V_RES + V_FP + V_SYNC) ? V_POL : ~V_POL;
    r.de  = mrun && mx < H_RES && my < V_RES;
    r.ls  = stb && mrun && mx == 0;
    r.fs  = stb && mrun && mx == 0 && my == 0;
    r.vb  = stb && mrun && mx == 0 && my == V_RES;
    r.run = mrun;
    r.fc  = FC_W'(mfc);
    q.push_back(r);
  endfunction

  // Advance the model across one clock edge with en level e.
  function automatic void update(input bit e);
    bit stb;
    bit last;
    stb  = (mdiv == CE_DIV - 1);
    mdiv = stb ? 0 : mdiv + 1;
    if (!mrun) begin
      if (stb && e) begin
        mrun  = 1'b1;
        mprev = 1'b1;
      end
    end else begin
      last = (mx == H_TOT - 1) && (my == V_TOT - 1);
      if (stb) begin
        if (last) begin
          mfc = (mfc + 1) % (1 << FC_W);
          if (!mprev && !e) mrun = 1'b0;
        end
        if (mx == H_TOT - 1) begin
          mx = 0;
          my = (my == V_TOT - 1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      mprev = e;
    end
  endfunction

  task automatic step(input logic e);
    @(negedge clk_100m);
    en = e;
    present();
    update(e);
  endtask

  task automatic do_reset(input logic e);
    @(negedge clk_100m);
    rst = 1'b1;
    en  = e;
    #2;
    compare("async_reset", sample(), reset_rec());
    @(negedge clk_100m);
    rst  = 1'b0;
    mdiv = 0; mx = 0; my = 0; mfc = 0; mrun = 1'b0; mprev = 1'b0;
    present();
    update(e);
  endtask

  // Monitor: every cycle out of reset, compare DUT against the queued expectation.
  initial begin
    rec_t exp;
    forever begin
      @(negedge clk_100m);
      #1;
      cyc++;
      if (!rst && q.size() > 0) begin
        exp = q.pop_front();
        compare("cycle", sample(), exp);
      end
    end
  end

  initial begin
    logic lvl;
    int   len;
    do_reset(1'b0);
    repeat (100) step(1'b0);

    // One full frame from the first start strobe.
    for (int i = 0; i < FR + 2 * CE_DIV; i++) step(1'b1);

    // Stop mid-frame: frame completes, then idle.
    for (int i = 0; i < 2 * FR && my != 2; i++) step(1'b1);
    for (int i = 0; i < 2 * FR && mrun; i++) step(1'b0);
    repeat (20) step(1'b0);

    // Stop then re-request before the frame ends.
    for (int i = 0; i < 2 * FR && !(mrun && my == 2); i++) step(1'b1);
    for (int i = 0; i < 2 * FR && my != 5; i++) step(1'b0);
    for (int i = 0; i < 2 * FR; i++) step(1'b1);

    // Async reset in the middle of the active area, then restart with en held.
    for (int i = 0; i < 2 * FR && !(mx == H_RES / 2 && my == V_RES / 2 && mdiv == 1); i++) step(1'b1);
    do_reset(1'b1);
    for (int i = 0; i < 5 * FR + 4 * CE_DIV; i++) step(1'b1);

    // Random en segments with occasional short glitches inside pixel periods.
    for (int s = 0; s < 10; s++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 900);
      for (int i = 0; i < len; i++) step(($urandom_range(0, 19) == 0) ? ~lvl : lvl);
    end

    repeat (2) @(negedge clk_100m);
    #2;
    checks++;
    if (q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL queue_drain: got %0d entries left, need 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
